// File: rtl/cpu_pkg.sv
// Shared types for the multicycle RV32I core: ALU ops, immediate formats, opcodes, control states.
// Imported by the control FSM, the ALU decoder and the datapath.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8
  } alu_op_t;

  typedef enum logic [2:0] {
    ADDI_SIGN_EXTEND   = 3'd0,
    SLLI_SIGN_EXTEND   = 3'd1,
    LW_SIGN_EXTEND     = 3'd2,
    SW_SIGN_EXTEND     = 3'd3,
    BRANCH_SIGN_EXTEND = 3'd4,
    JAL_SIGN_EXTEND    = 3'd5,
    LUI_SIGN_EXTEND    = 3'd6
  } sign_extend_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, ALU_WB, HALT
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps funct3/funct7 to an ALU operation and immediate format for R- and I-type ALU instructions.
// Purely combinational; flags encodings the core does not implement.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  input  logic         is_imm,
  output alu_op_t      alu_op,
  output sign_extend_t imm_type,
  output logic         illegal
);

  always_comb begin
    alu_op   = ALU_ADD;
    imm_type = ADDI_SIGN_EXTEND;
    illegal  = 1'b0;
    case (funct3)
      3'b000: begin
        // addi has no funct7 field; only the R-type form distinguishes sub
        if (!is_imm) begin
          if (funct7 == FUNCT7_ALT)       alu_op  = ALU_SUB;
          else if (funct7 != FUNCT7_BASE) illegal = 1'b1;
        end
      end
      3'b001: begin
        alu_op = ALU_SLL;
        if (is_imm) imm_type = SLLI_SIGN_EXTEND;
      end
      3'b010, 3'b011: begin
        alu_op = ALU_SLT;
        if (is_imm) illegal = 1'b1;
      end
      3'b100: alu_op = ALU_XOR;
      3'b101: begin
        if (is_imm) imm_type = SLLI_SIGN_EXTEND;
        if (funct7 == FUNCT7_BASE)     alu_op = ALU_SRL;
        else if (funct7 == FUNCT7_ALT) alu_op = ALU_SRA;
        else                           illegal = 1'b1;
      end
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: fetch/decode/execute/memory/write-back over a
// shared ALU and memory port with req/ready handshake, memory timeout and retired-instruction count.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic [6:0]   funct7,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic         adr_src,
  output logic         ir_write,
  output logic         pc_write,
  output logic         reg_write,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic         result_src,
  output alu_op_t      alu_op,
  output sign_extend_t imm_type,
  output logic         retire,
  output logic [31:0]  instr_count,
  output logic         halted,
  output logic [1:0]   err_code
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  ctrl_state_t  state, state_next;
  logic [1:0]   err_q, err_next;
  logic [CW-1:0] wait_cnt;
  logic         timeout;
  logic         is_imm;
  alu_op_t      dec_op;
  sign_extend_t dec_imm;
  logic         dec_illegal;

  assign is_imm   = (state == EXEC_I);
  assign err_code = err_q;
  // Fires on the waiting cycle that would bring the count up to MEM_TIMEOUT
  assign timeout  = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == WAIT_LAST);

  alu_decoder u_alu_decoder (
    .funct3   (funct3),
    .funct7   (funct7),
    .is_imm   (is_imm),
    .alu_op   (dec_op),
    .imm_type (dec_imm),
    .illegal  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      err_q       <= ERR_NONE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      err_q <= err_next;
      if (state_next != state)       wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = 1'b0;
    alu_op     = ALU_ADD;
    imm_type   = ADDI_SIGN_EXTEND;
    retire     = 1'b0;
    halted     = 1'b0;

    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = DECODE;
        else if (timeout) begin
          state_next = HALT;
          err_next   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        case (opcode)
          OPCODE_R:                   state_next = EXEC_R;
          OPCODE_I:                   state_next = EXEC_I;
          OPCODE_LOAD, OPCODE_STORE:  state_next = MEM_ADDR;
          default: begin
            state_next = HALT;
            err_next   = ERR_ILLEGAL;
          end
        endcase
      end
      EXEC_R, EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = is_imm ? SRC_B_IMM : SRC_B_RS2;
        alu_op    = dec_op;
        if (is_imm) imm_type = dec_imm;
        if (dec_illegal) begin
          state_next = HALT;
          err_next   = ERR_ILLEGAL;
        end else begin
          state_next = ALU_WB;
        end
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        if (opcode == OPCODE_STORE) begin
          imm_type   = SW_SIGN_EXTEND;
          state_next = MEM_WRITE;
        end else begin
          imm_type   = LW_SIGN_EXTEND;
          state_next = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = MEM_WB;
        else if (timeout) begin
          state_next = HALT;
          err_next   = ERR_TIMEOUT;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready;
        if (mem_ready) state_next = FETCH;
        else if (timeout) begin
          state_next = HALT;
          err_next   = ERR_TIMEOUT;
        end
      end
      HALT: halted = 1'b1;
      default: state_next = FETCH;
    endcase

    // Reset wins over any in-flight handshake: no side effects in the reset cycle
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected outputs are queued with the stimulus
// and compared at the falling edge, alongside a model of the retired-instruction counter.
module tb_multicycle_controller;
  import cpu_pkg::*;

  typedef struct packed {
    logic mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic result_src;
    logic [3:0] alu_op;
    logic [2:0] imm_type;
    logic retire, halted;
    logic [1:0] err_code;
  } obs_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic [6:0]   funct7 = '0;
  logic         mem_ready = 1'b0;
  logic         mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]   alu_src_a, alu_src_b;
  logic         result_src;
  alu_op_t      alu_op;
  sign_extend_t imm_type;
  logic         retire;
  logic [31:0]  instr_count;
  logic         halted;
  logic [1:0]   err_code;

  obs_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = '0;

  multicycle_controller #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .imm_type(imm_type), .retire(retire), .instr_count(instr_count),
    .halted(halted), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic obs_t fetch(input logic rdy);
    obs_t e = '0;
    e.mem_req = 1'b1; e.src_b = 2'd2; e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction

  function automatic obs_t decode();
    obs_t e = '0;
    return e;
  endfunction

  function automatic obs_t exec(input logic imm, input alu_op_t op, input sign_extend_t it);
    obs_t e = '0;
    e.src_a = 2'd1; e.src_b = imm ? 2'd1 : 2'd0; e.alu_op = op; e.imm_type = it;
    return e;
  endfunction

  function automatic obs_t alu_wb();
    obs_t e = '0;
    e.reg_write = 1'b1; e.retire = 1'b1;
    return e;
  endfunction

  function automatic obs_t mem_rd();
    obs_t e = '0;
    e.mem_req = 1'b1; e.adr_src = 1'b1;
    return e;
  endfunction

  function automatic obs_t mem_wb();
    obs_t e = '0;
    e.reg_write = 1'b1; e.result_src = 1'b1; e.retire = 1'b1;
    return e;
  endfunction

  function automatic obs_t mem_wr(input logic rdy);
    obs_t e = '0;
    e.mem_req = 1'b1; e.mem_we = 1'b1; e.adr_src = 1'b1; e.retire = rdy;
    return e;
  endfunction

  function automatic obs_t halt(input logic [1:0] err);
    obs_t e = '0;
    e.halted = 1'b1; e.err_code = err;
    return e;
  endfunction

  function automatic obs_t no_strobes(input obs_t e);
    obs_t r = e;
    r.mem_req = 1'b0; r.mem_we = 1'b0; r.ir_write = 1'b0;
    r.pc_write = 1'b0; r.reg_write = 1'b0; r.retire = 1'b0;
    return r;
  endfunction

  task automatic set_ir(input logic [31:0] ir);
    opcode = ir[6:0];
    funct3 = ir[14:12];
    funct7 = ir[31:25];
  endtask

  // One clock: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic rst, input logic rdy, input obs_t e, input string tag);
    obs_t got, want;
    reset = rst;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    got = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
           result_src, alu_op, imm_type, retire, halted, err_code};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s outputs: got %h expected %h", tag, got, want);
    end
    checks++;
    assert (instr_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s instr_count: got %0d expected %0d", tag, instr_count, exp_cnt);
    end
    if (rst) exp_cnt = '0;
    else if (want.retire) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, no_strobes(fetch(1'b0)), "reset");

    set_ir(32'h002081B3);
    cyc(1'b0, 1'b1, fetch(1'b1), "add_fetch");
    cyc(1'b0, 1'b1, decode(), "add_decode");
    cyc(1'b0, 1'b1, exec(1'b0, ALU_ADD, ADDI_SIGN_EXTEND), "add_exec");
    cyc(1'b0, 1'b1, alu_wb(), "add_wb");

    set_ir(32'h00500093);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, fetch(1'b0), "fetch_wait");
    cyc(1'b0, 1'b1, fetch(1'b1), "fetch_done");
    cyc(1'b0, 1'b1, decode(), "addi_decode");
    cyc(1'b0, 1'b1, exec(1'b1, ALU_ADD, ADDI_SIGN_EXTEND), "addi_exec");
    cyc(1'b0, 1'b1, alu_wb(), "addi_wb");

    set_ir(32'h0000A103);
    cyc(1'b0, 1'b1, fetch(1'b1), "lw_fetch");
    cyc(1'b0, 1'b1, decode(), "lw_decode");
    cyc(1'b0, 1'b1, exec(1'b1, ALU_ADD, LW_SIGN_EXTEND), "lw_addr");
    cyc(1'b0, 1'b0, mem_rd(), "lw_wait1");
    cyc(1'b0, 1'b0, mem_rd(), "lw_wait2");
    cyc(1'b0, 1'b1, mem_rd(), "lw_read");
    cyc(1'b0, 1'b1, mem_wb(), "lw_wb");

    set_ir(32'h40208133);
    cyc(1'b0, 1'b1, fetch(1'b1), "sub_fetch");
    cyc(1'b0, 1'b1, decode(), "sub_decode");
    cyc(1'b0, 1'b1, exec(1'b0, ALU_SUB, ADDI_SIGN_EXTEND), "sub_exec");
    cyc(1'b0, 1'b1, alu_wb(), "sub_wb");

    set_ir(32'h0020E1B3);
    cyc(1'b0, 1'b1, fetch(1'b1), "or_fetch");
    cyc(1'b0, 1'b1, decode(), "or_decode");
    cyc(1'b0, 1'b1, exec(1'b0, ALU_OR, ADDI_SIGN_EXTEND), "or_exec");
    cyc(1'b0, 1'b1, alu_wb(), "or_wb");

    set_ir(32'h4030D093);
    cyc(1'b0, 1'b1, fetch(1'b1), "srai_fetch");
    cyc(1'b0, 1'b1, decode(), "srai_decode");
    cyc(1'b0, 1'b1, exec(1'b1, ALU_SRA, SLLI_SIGN_EXTEND), "srai_exec");
    cyc(1'b0, 1'b1, alu_wb(), "srai_wb");

    set_ir(32'h0020A223);
    cyc(1'b0, 1'b1, fetch(1'b1), "sw_fetch");
    cyc(1'b0, 1'b1, decode(), "sw_decode");
    cyc(1'b0, 1'b1, exec(1'b1, ALU_ADD, SW_SIGN_EXTEND), "sw_addr");
    cyc(1'b0, 1'b1, mem_wr(1'b1), "sw_write");

    set_ir(32'h0000007F);
    cyc(1'b0, 1'b1, fetch(1'b1), "ill_fetch");
    cyc(1'b0, 1'b1, decode(), "ill_decode");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, halt(2'd1), "ill_halt");
    cyc(1'b1, 1'b1, halt(2'd1), "ill_reset");

    set_ir(32'h0020A223);
    cyc(1'b0, 1'b1, fetch(1'b1), "to_fetch");
    cyc(1'b0, 1'b1, decode(), "to_decode");
    cyc(1'b0, 1'b1, exec(1'b1, ALU_ADD, SW_SIGN_EXTEND), "to_addr");
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, mem_wr(1'b0), "to_wait");
    cyc(1'b0, 1'b1, halt(2'd2), "to_halt");
    cyc(1'b0, 1'b0, halt(2'd2), "to_halt_hold");
    cyc(1'b1, 1'b0, halt(2'd2), "to_reset");

    cyc(1'b0, 1'b1, fetch(1'b1), "rst_fetch");
    cyc(1'b0, 1'b1, decode(), "rst_decode");
    cyc(1'b0, 1'b1, exec(1'b1, ALU_ADD, SW_SIGN_EXTEND), "rst_addr");
    cyc(1'b0, 1'b0, mem_wr(1'b0), "rst_wait1");
    cyc(1'b0, 1'b0, mem_wr(1'b0), "rst_wait2");
    cyc(1'b1, 1'b1, no_strobes(mem_wr(1'b1)), "rst_mid_write");
    cyc(1'b0, 1'b0, fetch(1'b0), "rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
